// File: rtl/clock_phase_sequencer_pkg.sv
// Shared MCS-4 timing definitions: subcycle indices, sequencer FSM states,
// and small decode helpers used by the sequencer, the CPU and the bench.
package clock_phase_sequencer_pkg;

  // Instruction-cycle subcycles, A1 first, X3 last.
  typedef enum logic [2:0] {
    SC_A1 = 3'd0,
    SC_A2 = 3'd1,
    SC_A3 = 3'd2,
    SC_M1 = 3'd3,
    SC_M2 = 3'd4,
    SC_X1 = 3'd5,
    SC_X2 = 3'd6,
    SC_X3 = 3'd7
  } subcycle_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_POC     = 2'd0,
    ST_INIT    = 2'd1,
    ST_RUN     = 2'd2,
    ST_STOPPED = 2'd3
  } state_e;

  localparam int NUM_SUBCYCLES = 8;

  // One-hot phase vector for a subcycle (bit0 = A1 ... bit7 = X3).
  function automatic logic [7:0] phase_onehot(input subcycle_e sc);
    return 8'(1) << sc;
  endfunction

  // Clocks toggle in INIT and RUN only.
  function automatic logic is_running(input state_e s);
    return (s == ST_INIT) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/clock_phase_sequencer_if.sv
// Timing bus between the clock sequencer (master) and the CPU core (slave).
interface clock_phase_sequencer_if;
  logic       stop_req;
  logic       clk1;
  logic       clk2;
  logic [7:0] phase;
  logic       sync;
  logic       cycle_start;
  logic       cpu_reset;
  logic       stop_ack;

  modport master (
    input  stop_req,
    output clk1, clk2, phase, sync, cycle_start, cpu_reset, stop_ack
  );

  modport slave (
    output stop_req,
    input  clk1, clk2, phase, sync, cycle_start, cpu_reset, stop_ack
  );
endinterface

// File: rtl/clock_phase_sequencer_divider.sv
// Tick counter for one subcycle plus registered clk1/clk2 decode.
// run_now advances the counter (current FSM state); run_nxt gates the
// registered clock levels so they line up with the tick they decode.
module clock_phase_divider #(
  parameter int PERIOD = 8,
  parameter int CLK1_W = 2,
  parameter int GAP    = 1,
  parameter int CLK2_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_now,
  input  logic run_nxt,
  output logic wrap,
  output logic tick0_nxt,
  output logic clk1,
  output logic clk2
);

  localparam int TW = $clog2(PERIOD);
  localparam logic [TW-1:0] LAST   = TW'(PERIOD - 1);
  localparam logic [TW-1:0] C1_END = TW'(CLK1_W);
  localparam logic [TW-1:0] C2_BEG = TW'(CLK1_W + GAP);
  localparam logic [TW-1:0] C2_END = TW'(CLK1_W + GAP + CLK2_W);

  logic [TW-1:0] tick_q, tick_d;
  logic          clk1_q, clk1_d;
  logic          clk2_q, clk2_d;

  // Wrap only while counting; held at 0 when stopped so wrap stays low.
  assign wrap = run_now && (tick_q == LAST);

  // Next tick and clock-level decode of that next tick.
  always_comb begin
    tick_d = tick_q + TW'(1);
    if (rst || !run_now || wrap) tick_d = '0;
    tick0_nxt = (tick_d == '0);
    clk1_d    = run_nxt && (tick_d < C1_END);
    clk2_d    = run_nxt && (tick_d >= C2_BEG) && (tick_d < C2_END);
  end

  // Tick and clock-level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      clk1_q <= 1'b0;
      clk2_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      clk1_q <= clk1_d;
      clk2_q <= clk2_d;
    end
  end

  assign clk1 = clk1_q;
  assign clk2 = clk2_q;

endmodule

// File: rtl/clock_phase_sequencer.sv
// MCS-4 master clock sequencer: two-phase clock enables, 8-subcycle
// instruction timing, sync, power-on clear / CPU reset hold, and a
// stop/resume handshake taken only at instruction-cycle boundaries.
// All outputs are registered from next-state values so each output is
// valid in the same cycle as the tick/subcycle it decodes.
module clock_phase_sequencer
  import clock_phase_sequencer_pkg::*;
#(
  parameter int PERIOD       = 8,
  parameter int CLK1_W       = 2,
  parameter int GAP          = 1,
  parameter int CLK2_W       = 2,
  parameter int RESET_CYCLES = 8
) (
  input  logic                     sysclk,
  input  logic                     poc,
  clock_phase_sequencer_if.master  bus
);

  if (PERIOD < 6 || PERIOD > 255 || CLK1_W < 1 || CLK2_W < 1 || GAP < 1 ||
      CLK1_W + 2 * GAP + CLK2_W > PERIOD || RESET_CYCLES < 1 ||
      RESET_CYCLES > 255) begin : g_bad_params
    $error("clock_phase_sequencer: illegal timing parameters");
  end

  state_e      state_q, state_d;
  subcycle_e   sub_q, sub_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [7:0]  phase_q, phase_d;
  logic        sync_q, sync_d;
  logic        cs_q, cs_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        stop_ack_q, stop_ack_d;

  logic        run_now, run_nxt;
  logic        wrap, tick0_nxt, last_tick;
  logic        div_clk1, div_clk2;

  assign run_now   = is_running(state_q);
  assign run_nxt   = is_running(state_d);
  assign last_tick = wrap && (sub_q == SC_X3);

  clock_phase_divider #(
    .PERIOD (PERIOD),
    .CLK1_W (CLK1_W),
    .GAP    (GAP),
    .CLK2_W (CLK2_W)
  ) u_div (
    .clk       (sysclk),
    .rst       (poc),
    .run_now   (run_now),
    .run_nxt   (run_nxt),
    .wrap      (wrap),
    .tick0_nxt (tick0_nxt),
    .clk1      (div_clk1),
    .clk2      (div_clk2)
  );

  // Next state, subcycle, reset-cycle count and registered output decode.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    rcnt_d  = rcnt_q;
    if (wrap) sub_d = subcycle_e'(sub_q + 3'd1);

    case (state_q)
      ST_POC: begin
        state_d = ST_INIT;
        sub_d   = SC_A1;
      end
      ST_INIT: begin
        // stop_req deliberately not looked at while the CPU is held in reset
        if (last_tick) begin
          rcnt_d = rcnt_q + 8'd1;
          if (rcnt_q == 8'(RESET_CYCLES - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_tick && bus.stop_req) begin
          state_d = ST_STOPPED;
          sub_d   = SC_A1;
        end
      end
      ST_STOPPED: begin
        sub_d = SC_A1;
        if (!bus.stop_req) state_d = ST_RUN;
      end
      default: state_d = ST_POC;
    endcase

    if (poc) begin
      state_d = ST_POC;
      sub_d   = SC_A1;
      rcnt_d  = '0;
    end

    phase_d     = run_nxt ? phase_onehot(sub_d) : 8'h00;
    sync_d      = phase_d[7];
    cs_d        = run_nxt && (sub_d == SC_A1) && tick0_nxt;
    cpu_reset_d = (state_d == ST_POC) || (state_d == ST_INIT);
    stop_ack_d  = (state_d == ST_STOPPED);
  end

  // State and output registers; poc is the synchronous clear.
  always_ff @(posedge sysclk) begin
    if (poc) begin
      state_q     <= ST_POC;
      sub_q       <= SC_A1;
      rcnt_q      <= '0;
      phase_q     <= '0;
      sync_q      <= 1'b0;
      cs_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      stop_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      rcnt_q      <= rcnt_d;
      phase_q     <= phase_d;
      sync_q      <= sync_d;
      cs_q        <= cs_d;
      cpu_reset_q <= cpu_reset_d;
      stop_ack_q  <= stop_ack_d;
    end
  end

  assign bus.clk1        = div_clk1;
  assign bus.clk2        = div_clk2;
  assign bus.phase       = phase_q;
  assign bus.sync        = sync_q;
  assign bus.cycle_start = cs_q;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.stop_ack    = stop_ack_q;

endmodule

// File: tb/tb_clock_phase_sequencer.sv
// Directed bench for clock_phase_sequencer: default timing instance plus a
// tight-timing instance (PERIOD=6, CLK1_W=1, GAP=2, CLK2_W=1).
// Output vector layout: {clk1, clk2, phase[7:0], sync, cycle_start, cpu_reset, stop_ack}.
module tb_clock_phase_sequencer;

  logic sysclk;
  logic poc, poc2;
  int   n_chk, n_fail;
  int   t;

  localparam logic [13:0] RST_V  = 14'b00_00000000_0_0_1_0;
  localparam logic [13:0] STOP_V = 14'b00_00000000_0_0_0_1;

  clock_phase_sequencer_if bus ();
  clock_phase_sequencer_if bus2 ();

  clock_phase_sequencer dut (
    .sysclk (sysclk),
    .poc    (poc),
    .bus    (bus)
  );

  clock_phase_sequencer #(
    .PERIOD (6), .CLK1_W (1), .GAP (2), .CLK2_W (1), .RESET_CYCLES (8)
  ) dut2 (
    .sysclk (sysclk),
    .poc    (poc2),
    .bus    (bus2)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic logic [13:0] obs();
    return {bus.clk1, bus.clk2, bus.phase, bus.sync, bus.cycle_start,
            bus.cpu_reset, bus.stop_ack};
  endfunction

  // Expected default-timing outputs at sysclk tt after a (re)start at A1 tick 0.
  function automatic logic [13:0] run_exp(input int tt, input logic rst);
    int m;
    m = tt % 64;
    return {((m % 8) < 2), ((m % 8) == 3 || (m % 8) == 4), 8'(1 << (m / 8)),
            (m >= 56), (m == 0), rst, 1'b0};
  endfunction

  task automatic step();
    @(posedge sysclk);
    #1;
    t = t + 1;
  endtask

  task automatic test_reset();
    poc = 1'b1; poc2 = 1'b1;
    bus.stop_req = 1'b0; bus2.stop_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_chk++;
    if (obs() !== RST_V) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", obs(), RST_V);
    end
    n_chk++;
    if ({bus2.clk1, bus2.clk2, bus2.phase, bus2.cpu_reset, bus2.stop_ack} !== 12'b00_00000000_1_0) begin
      n_fail++; $display("FAIL reset_state2 got clk1=%b clk2=%b phase=%h rst=%b ack=%b",
                         bus2.clk1, bus2.clk2, bus2.phase, bus2.cpu_reset, bus2.stop_ack);
    end
  endtask

  // First instruction cycle after poc release.
  task automatic test_first_cycle();
    poc = 1'b0; t = -1;
    for (int i = 0; i < 64; i++) begin
      step();
      n_chk++;
      if (obs() !== run_exp(t, 1'b1)) begin
        n_fail++; $display("FAIL first_cycle t=%0d got=%h exp=%h", t, obs(), run_exp(t, 1'b1));
      end
    end
  endtask

  // cpu_reset held through 8 instruction cycles, falls with the 9th cycle_start.
  task automatic test_reset_hold();
    while (t < 520) begin
      step();
      n_chk++;
      if (obs() !== run_exp(t, t < 512)) begin
        n_fail++; $display("FAIL reset_hold t=%0d got=%h exp=%h", t, obs(), run_exp(t, t < 512));
      end
    end
  endtask

  task automatic test_stop_run();
    while ((t % 64) != 36) begin
      step();
      n_chk++;
      if (obs() !== run_exp(t, 1'b0)) begin
        n_fail++; $display("FAIL stop_pre t=%0d got=%h exp=%h", t, obs(), run_exp(t, 1'b0));
      end
    end
    bus.stop_req = 1'b1;
    while ((t % 64) != 63) begin
      step();
      n_chk++;
      if (obs() !== run_exp(t, 1'b0)) begin
        n_fail++; $display("FAIL stop_drain t=%0d got=%h exp=%h", t, obs(), run_exp(t, 1'b0));
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_chk++;
      if (obs() !== STOP_V) begin
        n_fail++; $display("FAIL stopped i=%0d got=%h exp=%h", i, obs(), STOP_V);
      end
    end
    bus.stop_req = 1'b0; t = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_chk++;
      if (obs() !== run_exp(t, 1'b0)) begin
        n_fail++; $display("FAIL resume t=%0d got=%h exp=%h", t, obs(), run_exp(t, 1'b0));
      end
    end
  endtask

  task automatic test_stop_in_init();
    poc = 1'b1;
    step(); step();
    n_chk++;
    if (obs() !== RST_V) begin
      n_fail++; $display("FAIL init_poc got=%h exp=%h", obs(), RST_V);
    end
    poc = 1'b0; bus.stop_req = 1'b1; t = -1;
    for (int i = 0; i < 576; i++) begin
      step();
      n_chk++;
      if (obs() !== run_exp(t, t < 512)) begin
        n_fail++; $display("FAIL init_stop t=%0d got=%h exp=%h", t, obs(), run_exp(t, t < 512));
      end
    end
    step();
    n_chk++;
    if (obs() !== STOP_V) begin
      n_fail++; $display("FAIL init_first_run_stop got=%h exp=%h", obs(), STOP_V);
    end
    bus.stop_req = 1'b0; t = -1;
    step();
    n_chk++;
    if (obs() !== run_exp(t, 1'b0)) begin
      n_fail++; $display("FAIL init_resume got=%h exp=%h", obs(), run_exp(t, 1'b0));
    end
  endtask

  task automatic test_poc_override();
    while ((t % 64) != 42) begin
      step();
      n_chk++;
      if (obs() !== run_exp(t, 1'b0)) begin
        n_fail++; $display("FAIL ovr_pre t=%0d got=%h exp=%h", t, obs(), run_exp(t, 1'b0));
      end
    end
    poc = 1'b1;
    step();
    n_chk++;
    if (obs() !== RST_V) begin
      n_fail++; $display("FAIL poc_mid_x1 got=%h exp=%h", obs(), RST_V);
    end
    poc = 1'b0; t = -1;
    for (int i = 0; i < 576; i++) begin
      step();
      n_chk++;
      if (obs() !== run_exp(t, t < 512)) begin
        n_fail++; $display("FAIL replay_init t=%0d got=%h exp=%h", t, obs(), run_exp(t, t < 512));
      end
      if (t == 530) bus.stop_req = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (obs() !== STOP_V) begin
        n_fail++; $display("FAIL ovr_stopped i=%0d got=%h exp=%h", i, obs(), STOP_V);
      end
    end
    poc = 1'b1;
    step();
    n_chk++;
    if (obs() !== RST_V) begin
      n_fail++; $display("FAIL poc_in_stopped got=%h exp=%h", obs(), RST_V);
    end
    poc = 1'b0; bus.stop_req = 1'b0; t = -1;
    for (int i = 0; i < 520; i++) begin
      step();
      n_chk++;
      if (obs() !== run_exp(t, t < 512)) begin
        n_fail++; $display("FAIL replay2 t=%0d got=%h exp=%h", t, obs(), run_exp(t, t < 512));
      end
    end
  endtask

  // Tight-timing instance over 10 instruction cycles (48 sysclk each).
  task automatic test_nonoverlap();
    int m, tk, fall_t;
    logic pc1, pc2;
    logic [7:0] eph;
    fall_t = -1; pc1 = 1'b0; pc2 = 1'b0;
    poc2 = 1'b0; t = -1;
    for (int i = 0; i < 480; i++) begin
      step();
      m = t % 48; tk = m % 6; eph = 8'(1 << (m / 6));
      n_chk++;
      if ({bus2.clk1, bus2.clk2, bus2.phase, bus2.cpu_reset} !== {(tk == 0), (tk == 3), eph, (t < 384)}) begin
        n_fail++; $display("FAIL nonoverlap_decode t=%0d got c1=%b c2=%b ph=%h rst=%b exp c1=%b c2=%b ph=%h rst=%b",
                           t, bus2.clk1, bus2.clk2, bus2.phase, bus2.cpu_reset, (tk == 0), (tk == 3), eph, (t < 384));
      end
      n_chk++;
      if (bus2.clk1 && bus2.clk2) begin
        n_fail++; $display("FAIL overlap t=%0d clk1=%b clk2=%b exp not both", t, bus2.clk1, bus2.clk2);
      end
      if (pc2 && !bus2.clk2) fall_t = t;
      if (bus2.clk1 && !pc1 && fall_t >= 0) begin
        n_chk++;
        if (t - fall_t < 2) begin
          n_fail++; $display("FAIL gap t=%0d got=%0d exp>=2", t, t - fall_t);
        end
      end
      pc1 = bus2.clk1; pc2 = bus2.clk2;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; t = 0;
    poc = 1'b1; poc2 = 1'b1;
    bus.stop_req = 1'b0; bus2.stop_req = 1'b0;
    test_reset();
    test_first_cycle();
    test_reset_hold();
    test_stop_run();
    test_stop_in_init();
    test_poc_override();
    test_nonoverlap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
